// File: rtl/joy_db15_tx.sv
// joy_db15_tx: emulates the DB15 adapter's 74HC165 chain on the JOY_CLK/JOY_LOAD/JOY_DATA link.
// The two joystick words are loaded in parallel while JOY_LOAD is low. They are shifted out
// LSB first (joystick1[0] first, joystick2[15] last) on rising JOY_CLK edges. The data is
// driven active-low on the wire.
// Optional feature: define JOYDB15_TX_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES clk_sys
// cycles without a JOY_CLK edge.
module joy_db15_tx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FRAME_BITS     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 4800
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    input  logic        JOY_CLK,
    input  logic        JOY_LOAD,
    output logic        JOY_DATA,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {StIdle, StLoaded, StShift} state_e;

    localparam logic [5:0] LastCnt = 6'(FRAME_BITS - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FRAME_BITS != 32 || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("joy_db15_tx: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic                   r_clk_hist;
    logic                   w_clk_rise;
    logic                   w_load_n;
    logic                   w_timeout;

    state_e                 r_state;
    logic [5:0]             r_bit_cnt;
    logic [31:0]            r_shreg;
    logic [31:0]            w_shreg_d;
    logic                   r_data;
    logic                   r_busy;
    logic                   r_done;
    logic [7:0]             r_frame_cnt;

    // Synchronise the asynchronous pins; keep one history flop for JOY_CLK edge detection
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '0;
            r_load_sync <= '1;
            r_clk_hist  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], JOY_CLK};
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], JOY_LOAD};
            r_clk_hist  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_clk_rise = r_clk_sync[SYNC_STAGES-1] & ~r_clk_hist;
    assign w_load_n   = r_load_sync[SYNC_STAGES-1];

`ifdef JOYDB15_TX_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_CYCLES + 1);

    logic [IdleW-1:0] r_idle_cnt;

    // Count silent cycles while a frame is pending; any edge or load restarts the count
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (!w_load_n || w_clk_rise || (r_state == StIdle)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign w_timeout = w_load_n && !w_clk_rise && (r_state != StIdle) &&
                       (r_idle_cnt == IdleW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Next shift-register value: transparent load dominates, then timeout flush, then shift
    always_comb begin
        w_shreg_d = r_shreg;
        if (!w_load_n) begin
            w_shreg_d = ~{joystick2, joystick1};
        end else if (w_timeout) begin
            w_shreg_d = '1;
        end else if (w_clk_rise) begin
            w_shreg_d = {1'b1, r_shreg[31:1]};
        end
    end

    // Frame FSM with registered outputs; JOY_DATA tracks the next shreg[0] to save a cycle
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_shreg     <= '1;
            r_data      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_shreg <= w_shreg_d;
            r_data  <= w_shreg_d[0];
            r_done  <= 1'b0;
            if (!w_load_n) begin
                r_state   <= StLoaded;
                r_bit_cnt <= '0;
                r_busy    <= 1'b0;
            end else if (w_timeout) begin
                r_state   <= StIdle;
                r_bit_cnt <= '0;
                r_busy    <= 1'b0;
            end else if (w_clk_rise) begin
                case (r_state)
                    StLoaded: begin
                        r_state   <= StShift;
                        r_bit_cnt <= 6'd1;
                        r_busy    <= 1'b1;
                    end
                    StShift: begin
                        if (r_bit_cnt == LastCnt) begin
                            r_state     <= StIdle;
                            r_bit_cnt   <= '0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + 8'd1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 6'd1;
                        end
                    end
                    // Idle edges shift ones through without counting
                    default: ;
                endcase
            end
        end
    end

    assign JOY_DATA   = r_data;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Self-checking bench for joy_db15_tx: table-driven frames, random frames, and hand-written
// reset, coincidence and timeout sequences against a pin-level model of the adapter.
module tb_joy_db15_tx;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] joystick1 = '0;
    logic [15:0] joystick2 = '0;
    logic        JOY_CLK = 1'b0;
    logic        JOY_LOAD = 1'b1;
    logic        JOY_DATA;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_pass = 0;
    int done_seen = 0;
    int exp_frames = 0;

    typedef struct {
        logic [15:0] j1;
        logic [15:0] j2;
        int          edges;
        logic        exp_done;
    } vec_t;

    vec_t vecs[7];

    always #10 clk_sys = ~clk_sys;

    joy_db15_tx #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_sys(clk_sys),
        .reset(reset),
        .joystick1(joystick1),
        .joystick2(joystick2),
        .JOY_CLK(JOY_CLK),
        .JOY_LOAD(JOY_LOAD),
        .JOY_DATA(JOY_DATA),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    // Count frame_done pulses (one per high cycle)
    always @(negedge clk_sys) if (frame_done) done_seen++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Model: after n rising JOY_CLK edges the wire shows bit n of the loaded word, inverted;
    // past the end of the frame the chain feeds released (1) bits.
    function automatic logic exp_bit(input logic [31:0] word, input int n);
        if (n < 32) return ~word[n];
        return 1'b1;
    endfunction

    task automatic run_frame(input logic [15:0] j1, input logic [15:0] j2, input int edges,
                             input logic exp_done, input string tag);
        logic [31:0] word;
        int          d0;
        word = {j2, j1};
        d0 = done_seen;
        joystick1 = j1;
        joystick2 = j2;
        JOY_CLK = 1'b0;
        JOY_LOAD = 1'b0;
        wait_cyc(6);
        check({tag, " load_data"}, JOY_DATA, exp_bit(word, 0));
        check({tag, " load_busy"}, busy, 1'b0);
        JOY_LOAD = 1'b1;
        wait_cyc(4);
        // Inputs outside the load window must not disturb the frame in flight
        joystick1 = 16'($urandom);
        joystick2 = 16'($urandom);
        for (int n = 1; n <= edges; n++) begin
            JOY_CLK = 1'b1;
            wait_cyc(4);
            check($sformatf("%s data[%0d]", tag, n), JOY_DATA, exp_bit(word, n));
            check($sformatf("%s busy[%0d]", tag, n), busy, (n < 32));
            JOY_CLK = 1'b0;
            wait_cyc(4);
        end
        if (exp_done) exp_frames++;
        check({tag, " done_pulses"}, done_seen - d0, exp_done);
        check({tag, " frame_cnt"}, frame_cnt, exp_frames[7:0]);
    endtask

    initial begin
        logic [31:0] w;
        int          d0;
        int          e;

        vecs[0] = '{j1: 16'h0011, j2: 16'h8000, edges: 32, exp_done: 1'b1};
        vecs[1] = '{j1: 16'hFFFF, j2: 16'h0000, edges: 32, exp_done: 1'b1};
        vecs[2] = '{j1: 16'h0000, j2: 16'hFFFF, edges: 32, exp_done: 1'b1};
        vecs[3] = '{j1: 16'hA5A5, j2: 16'h5A5A, edges: 10, exp_done: 1'b0};
        vecs[4] = '{j1: 16'h1234, j2: 16'h5678, edges: 32, exp_done: 1'b1};
        vecs[5] = '{j1: 16'hC3C3, j2: 16'h0F0F, edges: 36, exp_done: 1'b1};
        vecs[6] = '{j1: 16'h8001, j2: 16'h7FFE, edges: 0,  exp_done: 1'b0};

        // Reset state
        wait_cyc(5);
        check("rst JOY_DATA", JOY_DATA, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst frame_cnt", frame_cnt, 8'd0);
        check("rst frame_done", done_seen, 0);
        reset = 1'b0;
        wait_cyc(3);
        check("idle JOY_DATA", JOY_DATA, 1'b1);

        foreach (vecs[i])
            run_frame(vecs[i].j1, vecs[i].j2, vecs[i].edges, vecs[i].exp_done,
                      $sformatf("vec%0d", i));

        // Random frames, some short (aborted by the next load) and some overlong
        for (int k = 0; k < 20; k++) begin
            e = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : 32;
            run_frame(16'($urandom), 16'($urandom), e, (e >= 32), $sformatf("rnd%0d", k));
        end

        // Load fall and clock rise land in the same synchronised cycle: load must win
        run_frame(16'h0000, 16'h0000, 33, 1'b1, "pre_coin");
        joystick1 = 16'h0003;
        joystick2 = 16'h0000;
        w = {16'h0000, 16'h0003};
        JOY_LOAD = 1'b0;
        JOY_CLK = 1'b1;
        wait_cyc(2);
        check("coin latency2", JOY_DATA, 1'b1);
        wait_cyc(1);
        check("coin latency3", JOY_DATA, exp_bit(w, 0));
        wait_cyc(2);
        JOY_LOAD = 1'b1;
        wait_cyc(4);
        check("coin no_shift", JOY_DATA, exp_bit(w, 0));
        JOY_CLK = 1'b0;
        wait_cyc(4);
        for (int n = 1; n <= 2; n++) begin
            JOY_CLK = 1'b1;
            wait_cyc(4);
            check($sformatf("coin data[%0d]", n), JOY_DATA, exp_bit(w, n));
            JOY_CLK = 1'b0;
            wait_cyc(4);
        end

        // Fresh full frame after the partial one above
        run_frame(16'h00F0, 16'h0F00, 32, 1'b1, "post_coin");

        // Silence after 5 edges
        d0 = done_seen;
        w = {16'h9999, 16'h6666};
        run_frame(16'h6666, 16'h9999, 5, 1'b0, "tmo");
        wait_cyc(120);
`ifdef JOYDB15_TX_TIMEOUT_EN
        check("tmo busy", busy, 1'b0);
        check("tmo JOY_DATA", JOY_DATA, 1'b1);
`else
        check("tmo busy", busy, 1'b1);
        check("tmo JOY_DATA", JOY_DATA, exp_bit(w, 5));
`endif
        check("tmo frame_cnt", frame_cnt, exp_frames[7:0]);
        check("tmo no_done", done_seen - d0, 0);

        // Asynchronous reset mid-frame
        d0 = done_seen;
        joystick1 = 16'h00FF;
        joystick2 = 16'h0000;
        JOY_LOAD = 1'b0;
        wait_cyc(6);
        JOY_LOAD = 1'b1;
        wait_cyc(4);
        for (int n = 1; n <= 10; n++) begin
            JOY_CLK = 1'b1;
            wait_cyc(4);
            JOY_CLK = 1'b0;
            wait_cyc(4);
        end
        check("mid busy_before", busy, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("mid JOY_DATA", JOY_DATA, 1'b1);
        check("mid busy", busy, 1'b0);
        check("mid frame_cnt", frame_cnt, 8'd0);
        wait_cyc(3);
        reset = 1'b0;
        exp_frames = 0;
        check("mid no_done", done_seen - d0, 0);
        run_frame(16'h0101, 16'h1010, 32, 1'b1, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
